// File: rtl/audio_pkg.sv
// Shared types and constants for the audio codec datapaths (DAC playback, ADC capture).
package audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int WORD_W    = 2 * SAMPLE_W;
  // Bit counter covers the delay slot, SAMPLE_W data bits and one "done" value.
  localparam int BIT_CNT_W = $clog2(SAMPLE_W + 2);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LEFT,
    ST_RIGHT
  } dac_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous show-ahead FIFO with registered level/empty/full flags.
module audio_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             empty_q, full_q;
  logic             push, pop;

  assign push = wr_en_i && !full_q;
  assign pop  = rd_en_i && !empty_q;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == FULL_LVL);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and flags alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S playback serializer for the WM8731 DAC: FIFO-buffered stereo words shifted out
// MSB-first, slaved to codec bclk/daclrc sampled in the system clock domain.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic                           enable,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           dacfifo_empty,
  output logic [15:0]                    underrun_count,
  input  logic                           clr_underrun,
  input  logic                           bclk,
  input  logic                           daclrc,
  output logic                           dacdat
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SAMPLE_W);

  // [0],[1] synchronize the pin; [2] is the previous value for edge detection.
  logic [2:0] bclk_pipe_q, lrc_pipe_q;
  logic       bclk_fall, lrc_fall, lrc_rise;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_pipe_q <= '0;
      lrc_pipe_q  <= '0;
    end else begin
      bclk_pipe_q <= {bclk_pipe_q[1:0], bclk};
      lrc_pipe_q  <= {lrc_pipe_q[1:0], daclrc};
    end
  end

  assign bclk_fall =  bclk_pipe_q[2] && !bclk_pipe_q[1];
  assign lrc_fall  =  lrc_pipe_q[2]  && !lrc_pipe_q[1];
  assign lrc_rise  = !lrc_pipe_q[2]  &&  lrc_pipe_q[1];

  dac_state_t           state_q;
  logic [SAMPLE_W-1:0]  shift_q, hold_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 bit_q, dacdat_q;
  logic                 in_channel, load_left, load_right, shifting;

  stereo_sample_t       fifo_head;
  logic                 fifo_empty, fifo_full;

  audio_sample_fifo #(
    .WIDTH ($bits(stereo_sample_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .wr_en_i   (wr_valid),
    .wr_data_i (wr_data),
    .rd_en_i   (load_left),
    .rd_data_o (fifo_head),
    .level_o   (fifo_level),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  // An LR edge outranks a coincident bclk fall: the channel restarts, truncating any
  // unsent bits, and that bclk fall is not counted as the delay slot.
  assign in_channel = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
  assign load_left  = enable && lrc_fall && ((state_q == ST_ARMED) || (state_q == ST_RIGHT));
  assign load_right = enable && lrc_rise && (state_q == ST_LEFT);
  assign shifting   = enable && bclk_fall && in_channel;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      bit_q     <= 1'b0;
      dacdat_q  <= 1'b0;
    end else begin
      dacdat_q <= enable && in_channel && bit_q;
      if (!enable) begin
        state_q <= ST_IDLE;
        bit_q   <= 1'b0;
      end else if (load_left) begin
        state_q   <= ST_LEFT;
        shift_q   <= fifo_empty ? '0 : fifo_head.left;
        hold_q    <= fifo_empty ? '0 : fifo_head.right;
        bit_cnt_q <= '0;
        bit_q     <= 1'b0;
      end else if (load_right) begin
        state_q   <= ST_RIGHT;
        shift_q   <= hold_q;
        bit_cnt_q <= '0;
        bit_q     <= 1'b0;
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_ARMED;
      end else if (shifting) begin
        if (bit_cnt_q == '0) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          bit_q     <= 1'b0;
        end else if (bit_cnt_q <= LAST_BIT) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          bit_q     <= shift_q[SAMPLE_W-1];
          shift_q   <= {shift_q[SAMPLE_W-2:0], 1'b0};
        end else begin
          bit_q <= 1'b0;
        end
      end
    end
  end

  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (clr_underrun)
      underrun_cnt_d = '0;
    else if (load_left && fifo_empty && (underrun_cnt_q != 16'hFFFF))
      underrun_cnt_d = underrun_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) underrun_cnt_q <= '0;
    else                underrun_cnt_q <= underrun_cnt_d;
  end

  assign wr_ready       = !fifo_full;
  assign dacfifo_empty  = fifo_empty;
  assign underrun_count = underrun_cnt_q;
  assign dacdat         = dacdat_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench: codec bclk (16 system clocks) and 64-bclk daclrc frames, with
// per-frame vectors plus hand-written sequences for the multi-cycle corner cases.
module tb_audio_dac_serializer;

  logic        clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [6:0]  fifo_level;
  logic        dacfifo_empty;
  logic [15:0] underrun_count;
  logic        clr_underrun = 1'b0;
  logic        bclk = 1'b0;
  logic        daclrc = 1'b1;
  logic        dacdat;

  int n_applied = 0;
  int n_miscompares = 0;

  audio_dac_serializer #(.FIFO_DEPTH(64)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (reset_reset_n),
    .enable         (enable),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .fifo_level     (fifo_level),
    .dacfifo_empty  (dacfifo_empty),
    .underrun_count (underrun_count),
    .clr_underrun   (clr_underrun),
    .bclk           (bclk),
    .daclrc         (daclrc),
    .dacdat         (dacdat)
  );

  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        do_wr;
    logic [31:0] word;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic [15:0] exp_unr;
    logic        exp_empty;
  } frame_vec_t;

  frame_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_data  = w;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // One bclk period starting at a rising bclk (where daclrc may change); optional one-cycle
  // pulses land on the clock edge where the DUT acts on that daclrc edge. smp is dacdat
  // sampled 8 clocks after the falling bclk.
  task automatic bclk_period(input logic lr, input logic pclr, input logic pwr,
                             output logic smp);
    bclk   = 1'b1;
    daclrc = lr;
    repeat (2) @(negedge clk);
    clr_underrun = pclr;
    wr_valid     = pwr;
    @(negedge clk);
    clr_underrun = 1'b0;
    wr_valid     = 1'b0;
    repeat (5) @(negedge clk);
    bclk = 1'b0;
    repeat (8) @(negedge clk);
    smp = dacdat;
  endtask

  task automatic run_periods(input int first, input int last, output logic any_high);
    logic s;
    any_high = 1'b0;
    for (int p = first; p <= last; p++) begin
      bclk_period(p >= 32, 1'b0, 1'b0, s);
      any_high |= s;
    end
  endtask

  task automatic run_frame(input logic pclr, input logic pwr,
                           output logic [15:0] l, output logic [15:0] r, output logic stray);
    logic s;
    l = '0;
    r = '0;
    stray = 1'b0;
    for (int p = 0; p < 64; p++) begin
      bclk_period(p >= 32, pclr && (p == 0), pwr && (p == 0), s);
      if (p >= 1 && p <= 16)       l = {l[14:0], s};
      else if (p >= 33 && p <= 48) r = {r[14:0], s};
      else if (s)                  stray = 1'b1;
    end
  endtask

  logic [15:0] l, r;
  logic        stray, any, s;

  initial begin
    vecs[0] = '{1'b1, 32'hA5A5_5A5A, 16'hA5A5, 16'h5A5A, 16'd0, 1'b1};
    vecs[1] = '{1'b0, 32'h0,         16'h0000, 16'h0000, 16'd1, 1'b1};
    vecs[2] = '{1'b0, 32'h0,         16'h0000, 16'h0000, 16'd2, 1'b1};
    vecs[3] = '{1'b1, 32'hFFFF_0001, 16'hFFFF, 16'h0001, 16'd2, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_0001, 16'h8000, 16'h0001, 16'd2, 1'b1};
    vecs[5] = '{1'b0, 32'h0,         16'h0000, 16'h0000, 16'd3, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_dacdat",   32'(dacdat), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_level",    32'(fifo_level), 32'd0);
    check("rst_empty",    32'(dacfifo_empty), 32'd1);
    check("rst_underrun", 32'(underrun_count), 32'd0);
    reset_reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_wr) begin
        write_word(vecs[i].word);
        check($sformatf("v%0d_level_after_wr", i), 32'(fifo_level), 32'd1);
      end
      run_frame(1'b0, 1'b0, l, r, stray);
      check($sformatf("v%0d_left", i),     32'(l), 32'(vecs[i].exp_l));
      check($sformatf("v%0d_right", i),    32'(r), 32'(vecs[i].exp_r));
      check($sformatf("v%0d_stray", i),    32'(stray), 32'd0);
      check($sformatf("v%0d_underrun", i), 32'(underrun_count), 32'(vecs[i].exp_unr));
      check($sformatf("v%0d_empty", i),    32'(dacfifo_empty), 32'(vecs[i].exp_empty));
    end

    // Saturation from a preloaded count, then clear.
    force dut.underrun_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.underrun_cnt_q;
    @(negedge clk);
    check("sat_preload", 32'(underrun_count), 32'hFFFE);
    run_frame(1'b0, 1'b0, l, r, stray);
    check("sat_first", 32'(underrun_count), 32'hFFFF);
    run_frame(1'b0, 1'b0, l, r, stray);
    check("sat_hold", 32'(underrun_count), 32'hFFFF);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("clr_pulse", 32'(underrun_count), 32'd0);

    // Clear coincident with an underrun: clear wins.
    run_frame(1'b0, 1'b0, l, r, stray);
    check("pre_conc_clr", 32'(underrun_count), 32'd1);
    run_frame(1'b1, 1'b0, l, r, stray);
    check("conc_clr", 32'(underrun_count), 32'd0);

    // Write in the same cycle as the pop on an empty FIFO.
    wr_data = 32'hBEEF_1357;
    run_frame(1'b0, 1'b1, l, r, stray);
    check("wpop_left",     32'(l), 32'd0);
    check("wpop_underrun", 32'(underrun_count), 32'd1);
    check("wpop_level",    32'(fifo_level), 32'd1);
    run_frame(1'b0, 1'b0, l, r, stray);
    check("wpop_next_left",  32'(l), 32'hBEEF);
    check("wpop_next_right", 32'(r), 32'h1357);
    check("wpop_next_unr",   32'(underrun_count), 32'd1);
    check("wpop_next_empty", 32'(dacfifo_empty), 32'd1);

    // Enable dropped mid-left, re-enabled mid-frame.
    write_word(32'hFFFF_FFFF);
    write_word(32'h1234_8765);
    for (int p = 0; p < 4; p++) bclk_period(1'b0, 1'b0, 1'b0, s);
    check("en_bit_before_drop", 32'(s), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_dacdat", 32'(dacdat), 32'd0);
    check("en_drop_level",  32'(fifo_level), 32'd1);
    run_periods(4, 9, any);
    enable = 1'b1;
    begin
      logic any2;
      run_periods(10, 63, any2);
      any |= any2;
    end
    check("en_quiet_until_fall", 32'(any), 32'd0);
    check("en_level_kept",       32'(fifo_level), 32'd1);
    run_frame(1'b0, 1'b0, l, r, stray);
    check("en_next_left",  32'(l), 32'h1234);
    check("en_next_right", 32'(r), 32'h8765);

    // Fill past full with no frames running.
    wr_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      wr_data = {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
      @(negedge clk);
      if (i == 62) check("fill_ready_63", 32'(wr_ready), 32'd1);
      if (i == 63) check("fill_ready_64", 32'(wr_ready), 32'd0);
    end
    wr_valid = 1'b0;
    check("fill_level", 32'(fifo_level), 32'd64);
    check("fill_empty", 32'(dacfifo_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_frame(1'b0, 1'b0, l, r, stray);
      check($sformatf("fill_w%0d_left", i),  32'(l), 32'h1000 + 32'(i));
      check($sformatf("fill_w%0d_right", i), 32'(r), 32'h2000 + 32'(i));
    end
    check("fill_level_after", 32'(fifo_level), 32'd60);

    // Reset mid-RIGHT.
    run_periods(0, 40, any);
    reset_reset_n = 1'b0;
    #1;
    check("mrst_dacdat",   32'(dacdat), 32'd0);
    check("mrst_wr_ready", 32'(wr_ready), 32'd1);
    check("mrst_level",    32'(fifo_level), 32'd0);
    check("mrst_empty",    32'(dacfifo_empty), 32'd1);
    check("mrst_underrun", 32'(underrun_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_reset_n = 1'b1;
    @(negedge clk);
    write_word(32'hC3C3_3C3C);
    run_periods(41, 63, any);
    check("mrst_quiet", 32'(any), 32'd0);
    run_frame(1'b0, 1'b0, l, r, stray);
    check("mrst_left",  32'(l), 32'hC3C3);
    check("mrst_right", 32'(r), 32'h3C3C);
    check("mrst_stray", 32'(stray), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
